spi_txn_arbiter: RTL and testbench

Transaction controller that shares the single SPI master between several on-chip requesters. Accepts command/address/payload requests, arbitrates round-robin, assembles the master frame, pulses the master's transmit enable, tracks chip-select through the transfer, and returns the captured slave response (or a timeout error) to the winning requester. Sits between the brightness/config producers and the SPI master in the Zybo Z7-20 test fabric.

---
 rtl/spi_txn_arbiter_pkg.sv | 17 +
 rtl/spi_txn_arbiter_if.sv | 47 ++++
 rtl/spi_txn_arbiter_rr_arbiter.sv | 35 +++
 rtl/spi_txn_arbiter.sv | 160 ++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_txn_arbiter_pkg.sv
// Shared constants and helpers for the SPI transaction arbiter.
// Field widths mirror the SPI master's frame layout.
package spi_txn_arbiter_pkg;

    localparam int CMD_BITS     = 8;
    localparam int ADDR_BITS    = 8;
    localparam int PAYLOAD_BITS = 8;

    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;

    // Index width that stays legal for a single requester.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Requester, response and SPI-master signals of the transaction arbiter.
// slave = arbiter view, master = environment view.
interface spi_txn_arbiter_if
    import spi_txn_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int CMD_W  = CMD_BITS,
    parameter int ADDR_W = ADDR_BITS,
    parameter int DATA_W = PAYLOAD_BITS
);
    localparam int ID_W    = id_width(N_REQ);
    localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*CMD_W-1:0]  req_cmd;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;

    logic                    m_tx_enb;
    logic [FRAME_W-1:0]      m_frame;
    logic                    m_cs;
    logic [DATA_W:0]         m_rx_frame;

    logic                    busy;

    modport slave (
        input  req_valid, req_cmd, req_addr, req_data,
        input  rsp_ready, m_cs, m_rx_frame,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        output m_tx_enb, m_frame, busy
    );

    modport master (
        output req_valid, req_cmd, req_addr, req_data,
        output rsp_ready, m_cs, m_rx_frame,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        input  m_tx_enb, m_frame, busy
    );

endinterface

// File: rtl/spi_txn_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after
// the pointer wins, searching upward with wrap-around.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_pos;
    int w_sel;

    // Scan offsets high to low so the nearest hit is written last.
    always_comb begin
        w_pos = 0;
        w_sel = 0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N) w_pos = w_pos - N;
            if (i_req[w_pos]) begin
                w_sel = w_pos;
                o_any = 1'b1;
            end
        end
    end

    assign o_idx = IW'(w_sel);
    assign o_gnt = o_any ? (N'(1) << w_sel) : '0;

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master among N_REQ requesters: arbitrate, launch,
// follow chip-select, and hand the captured response back.
module spi_txn_arbiter
    import spi_txn_arbiter_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int CMD_W          = CMD_BITS,
    parameter int ADDR_W         = ADDR_BITS,
    parameter int DATA_W         = PAYLOAD_BITS,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             sysclk,
    input  logic             rst,
    spi_txn_arbiter_if.slave bus
);

    localparam int ID_W    = id_width(N_REQ);
    localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;
    localparam int TMR_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_END,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [N_REQ-1:0]   w_gnt;
    logic               w_any;
    logic               w_accept;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] w_frame_sel;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_err;
    logic [TMR_W-1:0]   r_timer;
    logic               w_tmr_clr;
    logic               w_tmr_inc;
    logic               w_tmr_last;
    logic               w_cap;
    logic               w_tout;
    logic               w_unused_rx_msb;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_rr (
        .i_req (bus.req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_any)
    );

    assign w_accept    = (r_state == S_IDLE) && w_any;
    assign w_frame_sel = {bus.req_cmd[int'(w_gnt_idx)*CMD_W +: CMD_W],
                          bus.req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W],
                          bus.req_data[int'(w_gnt_idx)*DATA_W +: DATA_W]};
    assign w_ptr_nxt   = (int'(w_gnt_idx) == N_REQ - 1) ? '0
                                                         : w_gnt_idx + ID_W'(1);
    assign w_tmr_last  = (r_timer >= TMR_LAST);

    // Only the low DATA_W bits of the master word carry response data.
    assign w_unused_rx_msb = bus.m_rx_frame[DATA_W];

    always_ff @(posedge sysclk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_clr   = 1'b0;
        w_tmr_inc   = 1'b0;
        w_cap       = 1'b0;
        w_tout      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_tmr_clr   = 1'b1;
                w_state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (bus.m_cs == CS_ASSERT) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = S_WAIT_END;
                end else if (w_tmr_last) begin
                    w_tout      = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            S_WAIT_END: begin
                if (bus.m_cs == CS_DEASSERT) begin
                    w_cap       = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_tmr_last) begin
                    w_tout      = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_frame    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_timer    <= '0;
        end else begin
            if (w_accept) begin
                r_frame  <= w_frame_sel;
                r_id     <= w_gnt_idx;
                r_rr_ptr <= w_ptr_nxt;
            end
            // Saturating phase timer; never wraps back to zero.
            if (w_tmr_clr) begin
                r_timer <= '0;
            end else if (w_tmr_inc && (r_timer != '1)) begin
                r_timer <= r_timer + TMR_W'(1);
            end
            if (w_cap) begin
                r_rsp_data <= bus.m_rx_frame[DATA_W-1:0];
                r_rsp_err  <= 1'b0;
            end else if (w_tout) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE) ? w_gnt : '0;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.m_tx_enb  = (r_state == S_LAUNCH);
    assign bus.m_frame   = (r_state == S_IDLE) ? '0 : r_frame;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized bench for spi_txn_arbiter with a transaction-level
// requester/slave model and a round-robin reference.
module tb_spi_txn_arbiter;

    localparam int N  = 2;
    localparam int CW = 8;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 1024;
    localparam int FW = CW + AW + DW;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    always #4 sysclk = ~sysclk;

    spi_txn_arbiter_if #(
        .N_REQ (N), .CMD_W (CW), .ADDR_W (AW), .DATA_W (DW)
    ) bus ();

    spi_txn_arbiter #(
        .N_REQ (N), .CMD_W (CW), .ADDR_W (AW), .DATA_W (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int ptr   = 0;

    logic          v    [N];
    logic [CW-1:0] cmd  [N];
    logic [AW-1:0] addr [N];
    logic [DW-1:0] dat  [N];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]           = v[i];
            bus.req_cmd[i*CW +: CW]    = cmd[i];
            bus.req_addr[i*AW +: AW]   = addr[i];
            bus.req_data[i*DW +: DW]   = dat[i];
        end
    endtask

    task automatic new_fields(input int i);
        cmd[i]  = CW'($urandom);
        addr[i] = AW'($urandom);
        dat[i]  = DW'($urandom);
    endtask

    // Reference: first valid requester at or after ptr, wrapping.
    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // One full transaction from IDLE: d = cycles before slave drops cs,
    // len = extra cycles with cs low, hold = cycles rsp_ready stays low.
    task automatic do_txn(input int d, input int len, input int hold,
                          input logic [DW:0] rx, input bit refresh,
                          output int w);
        logic [FW-1:0] ef;
        logic [DW-1:0] ed;
        drive();
        #1;
        w  = winner();
        ef = {cmd[w], addr[w], dat[w]};
        ed = rx[DW-1:0];
        chk("req_ready_grant", bus.req_ready, 32'(1) << w);
        tick();
        chk("tx_enb_pulse", bus.m_tx_enb, 1);
        chk("frame_launch", bus.m_frame, ef);
        ptr = (w + 1) % N;
        if (refresh) begin
            v[w] = 1'($urandom_range(0, 1));
            new_fields(w);
        end
        drive();
        if (d == 0) bus.m_cs = 1'b0;
        tick();
        chk("tx_enb_single", bus.m_tx_enb, 0);
        chk("req_ready_busy", bus.req_ready, 0);
        for (int i = 1; i <= d; i++) begin
            if (i == d) bus.m_cs = 1'b0;
            tick();
        end
        if (d == 0) tick();
        repeat (len) begin
            bus.m_rx_frame = (DW+1)'($urandom);
            tick();
        end
        chk("no_early_rsp", bus.rsp_valid, 0);
        bus.m_rx_frame = rx;
        bus.m_cs       = 1'b1;
        tick();
        bus.m_rx_frame = (DW+1)'($urandom);
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_id", bus.rsp_id, w);
        chk("rsp_data", bus.rsp_data, ed);
        chk("rsp_err", bus.rsp_err, 0);
        chk("frame_hold", bus.m_frame, ef);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_data", bus.rsp_data, ed);
            chk("hold_id", bus.rsp_id, w);
            chk("hold_ready0", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("idle_busy", bus.busy, 0);
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        chk("idle_frame", bus.m_frame, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_enb", bus.m_tx_enb, 0);
        chk("rst_frame", bus.m_frame, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        bit any;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0;
            new_fields(i);
        end
        drive();
        bus.rsp_ready  = 1'b0;
        bus.m_cs       = 1'b1;
        bus.m_rx_frame = '0;

        rst = 1'b1;
        tick();
        tick();
        chk_reset_vals();
        rst = 1'b0;

        // Both requesters continuously valid: strict alternation.
        v[0] = 1'b1;
        v[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_txn(k % 3, 2, 0, (DW+1)'($urandom), 1'b0, w);
            chk("rr_order", w, k % 2);
        end

        // Directed single request from requester 0.
        v[1]    = 1'b0;
        cmd[0]  = 8'h02;
        addr[0] = 8'h10;
        dat[0]  = 8'hA5;
        do_txn(1, 3, 1, 9'h13C, 1'b0, w);
        chk("single_id", w, 0);

        // Response back-pressure for 20 cycles.
        v[1] = 1'b1;
        do_txn(2, 2, 20, (DW+1)'($urandom), 1'b0, w);
        chk("hold_winner", w, 1);

        // Slave never asserts chip-select.
        v[1] = 1'b0;
        drive();
        #1;
        chk("to_grant", bus.req_ready, 1);
        tick();
        chk("to_tx_enb", bus.m_tx_enb, 1);
        ptr  = 1;
        v[0] = 1'b0;
        drive();
        tick();
        repeat (TO - 1) tick();
        chk("to_not_early", bus.rsp_valid, 0);
        tick();
        chk("to_rsp_valid", bus.rsp_valid, 1);
        chk("to_rsp_err", bus.rsp_err, 1);
        chk("to_rsp_data", bus.rsp_data, 0);
        chk("to_rsp_id", bus.rsp_id, 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("to_idle", bus.busy, 0);

        // Reset in the middle of a transfer.
        v[0] = 1'b1;
        new_fields(0);
        drive();
        #1;
        chk("mid_grant", bus.req_ready, 1);
        bus.m_cs = 1'b0;
        tick();
        v[0] = 1'b0;
        drive();
        tick();
        tick();
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        chk_reset_vals();
        rst      = 1'b0;
        bus.m_cs = 1'b1;
        ptr      = 0;
        v[0]     = 1'b1;
        v[1]     = 1'b1;
        drive();
        #1;
        chk("ptr_after_rst", bus.req_ready, 1);
        v[0] = 1'b0;
        new_fields(1);
        do_txn(1, 2, 0, (DW+1)'($urandom), 1'b0, w);
        chk("id1_only", w, 1);
        v[1] = 1'b0;

        // Random traffic with idle gaps.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < N; j++) v[j] = 1'b0;
                drive();
                tick();
                chk("idle_stay", bus.busy, 0);
                chk("idle_no_ready", bus.req_ready, 0);
            end
            any = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (!v[j] && $urandom_range(0, 1) == 1) begin
                    v[j] = 1'b1;
                    new_fields(j);
                end
                if (v[j]) any = 1'b1;
            end
            if (!any) begin
                w    = int'($urandom_range(0, N - 1));
                v[w] = 1'b1;
                new_fields(w);
            end
            do_txn(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 3)), (DW+1)'($urandom), 1'b1, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
